// File: rtl/axis_packetizer_if.sv
// rtl/axis_packetizer_if.sv - AXI-Stream bundle (axi_if) used for the packetizer's s/m ports
interface axi_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_packetizer.sv
// rtl/axis_packetizer.sv - fixed-length AXI-Stream framer with 2-entry skid output stage
// Optional packet counter port pkt_count is enabled by defining PKTZ_STATS_EN.
module axis_packetizer #(
    parameter int DATA_W  = 32,
    parameter int USER_W  = 8,
    parameter int PKT_LEN = 256
) (
    input  logic        clk,
    input  logic        rst,
    axi_if.slave        s_axi_if,
    axi_if.master       m_axi_if
`ifdef PKTZ_STATS_EN
    ,
    output logic [31:0] pkt_count
`endif
);
    localparam int CNT_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int BEAT_W = DATA_W + USER_W + 1;

    logic [CNT_W-1:0]  r_cnt;
    logic              r_s_ready;
    logic              r_out_valid;
    logic [BEAT_W-1:0] r_out_beat;
    logic              r_skid_valid;
    logic [BEAT_W-1:0] r_skid_beat;

    logic              w_in_fire;
    logic              w_in_last;
    logic              w_out_free;
    logic [BEAT_W-1:0] w_in_beat;
    logic              w_out_valid_nxt;
    logic [BEAT_W-1:0] w_out_beat_nxt;
    logic              w_skid_valid_nxt;
    logic [BEAT_W-1:0] w_skid_beat_nxt;

    assign w_in_fire  = s_axi_if.tvalid && r_s_ready;
    assign w_in_last  = (r_cnt == CNT_W'(PKT_LEN - 1));
    assign w_in_beat  = {s_axi_if.tdata, s_axi_if.tuser, w_in_last};
    assign w_out_free = !r_out_valid || m_axi_if.tready;

    // r_s_ready mirrors an empty skid, so an accepted beat never meets a full skid
    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_out_beat_nxt   = r_out_beat;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_beat_nxt  = r_skid_beat;
        if (w_out_free) begin
            if (r_skid_valid) begin
                w_out_valid_nxt  = 1'b1;
                w_out_beat_nxt   = r_skid_beat;
                w_skid_valid_nxt = 1'b0;
            end else if (w_in_fire) begin
                w_out_valid_nxt = 1'b1;
                w_out_beat_nxt  = w_in_beat;
            end else begin
                w_out_valid_nxt = 1'b0;
            end
        end else if (w_in_fire) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_beat_nxt  = w_in_beat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_s_ready    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_beat   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_beat  <= '0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_out_beat   <= w_out_beat_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_beat  <= w_skid_beat_nxt;
            r_s_ready    <= !w_skid_valid_nxt;
            if (w_in_fire) begin
                r_cnt <= w_in_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign s_axi_if.tready = r_s_ready;
    assign m_axi_if.tvalid = r_out_valid;
    assign m_axi_if.tdata  = r_out_beat[BEAT_W-1 -: DATA_W];
    assign m_axi_if.tuser  = r_out_beat[USER_W:1];
    assign m_axi_if.tlast  = r_out_beat[0];

`ifdef PKTZ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count <= '0;
        end else if (r_out_valid && m_axi_if.tready && r_out_beat[0]) begin
            pkt_count <= pkt_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_axis_packetizer.sv
// tb/tb_axis_packetizer.sv - randomized scoreboard bench for axis_packetizer (PKT_LEN 256 and 4)
module tb_axis_packetizer;
    localparam int DW  = 32;
    localparam int UW  = 8;
    localparam int PL  = 256;
    localparam int PL4 = 4;

    typedef logic [DW+UW:0] beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_if #(.DATA_W(DW), .USER_W(UW)) s_axi_if ();
    axi_if #(.DATA_W(DW), .USER_W(UW)) m_axi_if ();
    axi_if #(.DATA_W(DW), .USER_W(UW)) s4_if ();
    axi_if #(.DATA_W(DW), .USER_W(UW)) m4_if ();

`ifdef PKTZ_STATS_EN
    logic [31:0] pkt_count;
    logic [31:0] pkt_count4;
`endif

    axis_packetizer #(.DATA_W(DW), .USER_W(UW), .PKT_LEN(PL)) dut (
        .clk(clk), .rst(rst), .s_axi_if(s_axi_if), .m_axi_if(m_axi_if)
`ifdef PKTZ_STATS_EN
        , .pkt_count(pkt_count)
`endif
    );

    axis_packetizer #(.DATA_W(DW), .USER_W(UW), .PKT_LEN(PL4)) dut4 (
        .clk(clk), .rst(rst), .s_axi_if(s4_if), .m_axi_if(m4_if)
`ifdef PKTZ_STATS_EN
        , .pkt_count(pkt_count4)
`endif
    );

    int    pass_cnt   = 0;
    int    chk_cnt    = 0;
    beat_t exp_q[$];
    beat_t exp4_q[$];
    int    beat_idx   = 0;
    int    model_pkts = 0;
    int    model4_pkts = 0;
    int    mode       = 0;   // 0: m_tready=1, 1: random 50%, 2: stalled
    bit    rand_user  = 1'b0;
    bit    done4      = 1'b0;
    logic [DW-1:0] next_data = 1;
    logic [UW-1:0] next_user = 8'hA5;

    beat_t hold;
    beat_t got;
    beat_t e;
    bit    have_hold = 1'b0;
    beat_t got4;
    beat_t e4;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: beat k after reset (0-based) closes a packet iff k mod PKT_LEN == PKT_LEN-1
    task automatic send(input int n, input int idle_pct, input int max_cyc, output int sent);
        int cyc = 0;
        sent = 0;
        while (sent < n && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            s_axi_if.tvalid = ($urandom_range(99) >= idle_pct);
            s_axi_if.tdata  = next_data;
            s_axi_if.tuser  = next_user;
            if (s_axi_if.tvalid && s_axi_if.tready) begin
                exp_q.push_back({next_data, next_user, ((beat_idx % PL) == PL - 1)});
                beat_idx++;
                next_data++;
                if (rand_user) next_user = UW'($urandom);
                sent++;
            end
        end
    endtask

    task automatic run(input int n, input int idle_pct);
        int sent;
        send(n, idle_pct, n * 10 + 200, sent);
        chk(sent == n, "send_budget", sent, n);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            s_axi_if.tvalid = 1'b0;
        end
    endtask

    task automatic drain();
        int cyc = 0;
        idle(1);
        while ((exp_q.size() != 0 || m_axi_if.tvalid) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_pkts();
`ifdef PKTZ_STATS_EN
        chk(pkt_count == model_pkts, "pkt_count", pkt_count, model_pkts);
`endif
    endtask

    // Monitor for the PKT_LEN=256 instance
    initial begin
        m_axi_if.tready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_hold = 1'b0;
            end else begin
                got = {m_axi_if.tdata, m_axi_if.tuser, m_axi_if.tlast};
                if (have_hold)
                    chk({m_axi_if.tvalid, got} == {1'b1, hold}, "stall_hold", {m_axi_if.tvalid, got}, {1'b1, hold});
                case (mode)
                    0:       m_axi_if.tready = 1'b1;
                    1:       m_axi_if.tready = 1'($urandom_range(1));
                    default: m_axi_if.tready = 1'b0;
                endcase
                if (m_axi_if.tvalid && m_axi_if.tready) begin
                    chk(exp_q.size() > 0, "unexpected_beat", got, 0);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk(got == e, "beat", got, e);
                        if (e[0]) model_pkts++;
                    end
                end
                have_hold = m_axi_if.tvalid && !m_axi_if.tready;
                hold = got;
            end
        end
    end

    // Monitor for the PKT_LEN=4 instance
    initial begin
        m4_if.tready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && m4_if.tvalid) begin
                got4 = {m4_if.tdata, m4_if.tuser, m4_if.tlast};
                chk(exp4_q.size() > 0, "unexpected_beat4", got4, 0);
                if (exp4_q.size() > 0) begin
                    e4 = exp4_q.pop_front();
                    chk(got4 == e4, "beat4", got4, e4);
                    if (e4[0]) model4_pkts++;
                end
            end
        end
    end

    // Stimulus for the PKT_LEN=4 instance: 12 beats, expect tlast on 4, 8, 12
    initial begin
        int sent4 = 0;
        int cyc4 = 0;
        s4_if.tvalid = 1'b0;
        s4_if.tdata  = '0;
        s4_if.tuser  = '0;
        s4_if.tlast  = 1'b0;
        wait (!rst);
        while (sent4 < 12 && cyc4 < 200) begin
            @(negedge clk);
            cyc4++;
            s4_if.tvalid = 1'b1;
            s4_if.tdata  = $urandom;
            s4_if.tuser  = UW'($urandom);
            if (s4_if.tready) begin
                exp4_q.push_back({s4_if.tdata, s4_if.tuser, ((sent4 % PL4) == PL4 - 1)});
                sent4++;
            end
        end
        @(negedge clk);
        s4_if.tvalid = 1'b0;
        cyc4 = 0;
        while ((exp4_q.size() != 0 || m4_if.tvalid) && cyc4 < 100) begin
            @(negedge clk);
            cyc4++;
        end
        chk(sent4 == 12, "send4_budget", sent4, 12);
        chk(exp4_q.size() == 0, "drain4_empty", exp4_q.size(), 0);
        chk(model4_pkts == 3, "pkt_tlast_count4", model4_pkts, 3);
`ifdef PKTZ_STATS_EN
        chk(pkt_count4 == 32'd3, "pkt_count4", pkt_count4, 3);
`endif
        done4 = 1'b1;
    end

    initial begin
        int acc;
        int w;
        s_axi_if.tvalid = 1'b0;
        s_axi_if.tdata  = '0;
        s_axi_if.tuser  = '0;
        s_axi_if.tlast  = 1'b0;
        repeat (3) @(negedge clk);
        chk(m_axi_if.tvalid == 1'b0, "rst_m_tvalid", m_axi_if.tvalid, 0);
        chk(s_axi_if.tready == 1'b0, "rst_s_tready", s_axi_if.tready, 0);
        chk({m_axi_if.tdata, m_axi_if.tuser, m_axi_if.tlast} == '0, "rst_m_outputs",
            {m_axi_if.tdata, m_axi_if.tuser, m_axi_if.tlast}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk(s_axi_if.tready == 1'b1, "s_tready_after_rst", s_axi_if.tready, 1);

        // Continuous 1..600, tuser 0xA5, m_tready=1
        run(600, 0);
        drain();
        chk(model_pkts == 2, "pkts_after_600", model_pkts, 2);
        check_pkts();

        // Random m_tready, random tuser
        rand_user = 1'b1;
        mode = 1;
        run(2048, 0);
        drain();
        check_pkts();

        // Output stalled for 10 cycles: at most two beats fit
        mode = 2;
        repeat (2) @(negedge clk);
        send(10, 0, 10, acc);
        chk(acc <= 2, "stall_accepts", acc, 2);
        chk(s_axi_if.tready == 1'b0, "stall_s_tready", s_axi_if.tready, 0);
        mode = 0;
        drain();

        // Source pause mid-packet, plus random idles with random ready
        run(100, 0);
        idle(50);
        run(300, 0);
        mode = 1;
        run(500, 30);
        mode = 0;
        drain();
        check_pkts();

        // Reset mid-packet
        run(130, 0);
        @(negedge clk);
        rst = 1'b1;
        s_axi_if.tvalid = 1'b0;
        exp_q.delete();
        beat_idx   = 0;
        model_pkts = 0;
        @(negedge clk);
        chk(m_axi_if.tvalid == 1'b0, "midrst_m_tvalid", m_axi_if.tvalid, 0);
        chk(s_axi_if.tready == 1'b0, "midrst_s_tready", s_axi_if.tready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk(s_axi_if.tready == 1'b1, "s_tready_after_midrst", s_axi_if.tready, 1);
        run(300, 0);
        drain();
        chk(model_pkts == 1, "pkts_after_midrst", model_pkts, 1);
        check_pkts();

        w = 0;
        while (!done4 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk(done4, "dut4_done", done4, 1);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
